// File: rtl/iter_alu_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iter_alu_unit_pkg
// Description : FUNCT opcode constants and FSM state encoding for the
//               iterative execute-stage ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package iter_alu_unit_pkg;

  localparam logic [3:0] FN_ADD   = 4'd0;
  localparam logic [3:0] FN_SUB   = 4'd1;
  localparam logic [3:0] FN_AND   = 4'd2;
  localparam logic [3:0] FN_OR    = 4'd3;
  localparam logic [3:0] FN_NOR   = 4'd4;
  localparam logic [3:0] FN_XOR   = 4'd5;
  localparam logic [3:0] FN_LU    = 4'd6;
  localparam logic [3:0] FN_SLT   = 4'd7;
  localparam logic [3:0] FN_SLLV  = 4'd8;
  localparam logic [3:0] FN_SRLV  = 4'd9;
  localparam logic [3:0] FN_SRAV  = 4'd10;
  localparam logic [3:0] FN_SLTU  = 4'd11;
  localparam logic [3:0] FN_MUL   = 4'd12;
  localparam logic [3:0] FN_MULHU = 4'd13;
  localparam logic [3:0] FN_DIVU  = 4'd14;
  localparam logic [3:0] FN_REMU  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/iter_alu_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : iter_alu_unit_if
// Description : Operand/result handshake bundle of the iterative ALU.
//               master = front end + consumer, slave = the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface iter_alu_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       funct;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, funct, op1, op2, out_ready,
    input  in_ready, out_valid, out_data, div_by_zero, busy
  );

  modport slave (
    input  in_valid, funct, op1, op2, out_ready,
    output in_ready, out_valid, out_data, div_by_zero, busy
  );
endinterface
`default_nettype wire

// File: rtl/iter_alu_unit_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative shift-add multiplier / restoring divider.
//               One step per cycle; the first step is taken on the start
//               edge straight from a_i/b_i, so WIDTH steps end WIDTH-1
//               cycles after start and step_done_o flags that last step.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             abort_i,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             step_done_o,
  output logic [WIDTH-1:0] prod_lo_o,
  output logic [WIDTH-1:0] prod_hi_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0]   cnt_q;
  logic               running_q;
  logic               is_div_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;

  logic               step_en;
  logic               div_mode;
  logic [2*WIDTH-1:0] acc_src;
  logic [WIDTH-1:0]   b_src;
  logic [WIDTH-1:0]   quot_src;
  logic [WIDTH-1:0]   rem_src;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   rem_d;

  // One multiply or divide step; sources come from the ports on the start edge.
  always_comb begin
    step_en   = start_i | running_q;
    div_mode  = start_i ? is_div_i : is_div_q;
    acc_src   = start_i ? {{WIDTH{1'b0}}, a_i} : acc_q;
    b_src     = start_i ? b_i : b_q;
    quot_src  = start_i ? a_i : quot_q;
    rem_src   = start_i ? '0 : rem_q;
    // Shift-add: add multiplicand to the upper half when the LSB is set, then shift right.
    mul_sum   = {1'b0, acc_src[2*WIDTH-1:WIDTH]} + (acc_src[0] ? {1'b0, b_src} : '0);
    acc_d     = {mul_sum, acc_src[WIDTH-1:1]};
    // Restoring: a borrow (top bit set) means the shifted remainder is kept.
    div_trial = {rem_src, quot_src[WIDTH-1]} - {1'b0, b_src};
    rem_d     = div_trial[WIDTH] ? {rem_src[WIDTH-2:0], quot_src[WIDTH-1]} : div_trial[WIDTH-1:0];
    quot_d    = {quot_src[WIDTH-2:0], ~div_trial[WIDTH]};
  end

  assign step_done_o = running_q & (cnt_q == CNT_W'(WIDTH - 2));
  assign prod_lo_o   = acc_q[WIDTH-1:0];
  assign prod_hi_o   = acc_q[2*WIDTH-1:WIDTH];
  assign quot_o      = quot_q;
  assign rem_o       = rem_q;

  // Step counter, operand latches and the shared datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
      is_div_q  <= 1'b0;
      b_q       <= '0;
      acc_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
    end else if (abort_i) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else begin
      if (start_i) begin
        cnt_q     <= '0;
        running_q <= 1'b1;
        is_div_q  <= is_div_i;
        b_q       <= b_i;
      end else if (running_q) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (step_done_o) begin
          running_q <= 1'b0;
        end
      end
      if (step_en) begin
        if (div_mode) begin
          quot_q <= quot_d;
          rem_q  <= rem_d;
        end else begin
          acc_q <= acc_d;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/iter_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : iter_alu_unit
// Description : Registered execute-stage ALU with valid/ready handshakes.
//               Single-cycle ops load OUT at the accepting edge; MUL/MULHU/
//               DIVU/REMU run on muldiv_iter and are emitted from DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module iter_alu_unit
  import iter_alu_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  iter_alu_unit_if.slave  bus_if
);
  state_e           state_q;
  logic [3:0]       funct_q;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic             dbz_q;

  logic             out_free;
  logic             in_ready;
  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             op2_zero;
  logic             start;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] md_res;
  logic             step_done;
  logic [WIDTH-1:0] prod_lo, prod_hi, quot, rem;

  // Handshake qualification and the single-cycle result (incl. divide-by-zero).
  always_comb begin
    out_free = ~out_valid_q | bus_if.out_ready;
    in_ready = (state_q == ST_IDLE) & out_free & ~flush_i & ~rst_i;
    accept   = bus_if.in_valid & in_ready;
    is_mul   = (bus_if.funct == FN_MUL) | (bus_if.funct == FN_MULHU);
    is_div   = (bus_if.funct == FN_DIVU) | (bus_if.funct == FN_REMU);
    op2_zero = (bus_if.op2 == '0);
    start    = accept & (is_mul | (is_div & ~op2_zero));
    shamt    = bus_if.op2[SHAMT_W-1:0];
    alu_res  = '0;
    case (bus_if.funct)
      FN_ADD:  alu_res = bus_if.op1 + bus_if.op2;
      FN_SUB:  alu_res = bus_if.op1 - bus_if.op2;
      FN_AND:  alu_res = bus_if.op1 & bus_if.op2;
      FN_OR:   alu_res = bus_if.op1 | bus_if.op2;
      FN_NOR:  alu_res = ~(bus_if.op1 | bus_if.op2);
      FN_XOR:  alu_res = bus_if.op1 ^ bus_if.op2;
      FN_LU:   alu_res = {bus_if.op2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus_if.op1) < $signed(bus_if.op2)};
      FN_SLLV: alu_res = bus_if.op1 << shamt;
      FN_SRLV: alu_res = bus_if.op1 >> shamt;
      FN_SRAV: alu_res = $unsigned($signed(bus_if.op1) >>> shamt);
      FN_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus_if.op1 < bus_if.op2};
      FN_DIVU: alu_res = '1;
      FN_REMU: alu_res = bus_if.op1;
      default: alu_res = '0;
    endcase
  end

  // Select the engine result according to the latched opcode.
  always_comb begin
    md_res = prod_lo;
    case (funct_q)
      FN_MULHU: md_res = prod_hi;
      FN_DIVU:  md_res = quot;
      FN_REMU:  md_res = rem;
      default:  md_res = prod_lo;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .abort_i     (flush_i),
    .start_i     (start),
    .is_div_i    (is_div),
    .a_i         (bus_if.op1),
    .b_i         (bus_if.op2),
    .step_done_o (step_done),
    .prod_lo_o   (prod_lo),
    .prod_hi_o   (prod_hi),
    .quot_o      (quot),
    .rem_o       (rem)
  );

  // Control FSM with the registered output stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      funct_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else if (flush_i) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      if (bus_if.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= is_mul ? ST_MUL : ST_DIV;
            funct_q <= bus_if.funct;
          end else if (accept) begin
            out_q       <= alu_res;
            out_valid_q <= 1'b1;
            dbz_q       <= is_div;
          end
        end
        ST_MUL, ST_DIV: begin
          if (step_done) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_free) begin
            out_q       <= md_res;
            out_valid_q <= 1'b1;
            dbz_q       <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_if.in_ready    = in_ready;
  assign bus_if.out_valid   = out_valid_q;
  assign bus_if.out_data    = out_q;
  assign bus_if.div_by_zero = dbz_q;
  assign bus_if.busy        = (state_q != ST_IDLE);
endmodule
`default_nettype wire
